// File: rtl/fp_button_capture_if.sv
// Button capture bus: raw pins and clear control in, debounced state,
// edge pulses and per-button press counters out.
interface fp_button_capture_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0]   btn_n;
  logic               clear_counts;
  logic [N_BTN-1:0]   btn_state;
  logic [N_BTN-1:0]   btn_press;
  logic [N_BTN-1:0]   btn_release;
  logic [4*N_BTN-1:0] press_count;

  modport master (
    output btn_n,
    output clear_counts,
    input  btn_state,
    input  btn_press,
    input  btn_release,
    input  press_count
  );

  modport slave (
    input  btn_n,
    input  clear_counts,
    output btn_state,
    output btn_press,
    output btn_release,
    output press_count
  );
endinterface

// File: rtl/fp_button_capture.sv
// Debounces active-low push buttons on ti_clk and exposes clean state,
// one-cycle press/release pulses and wrapping 4-bit press counters.
module fp_button_capture #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 48000
) (
  input logic                ti_clk,
  input logic                reset,
  fp_button_capture_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] sync1_r;
  logic [N_BTN-1:0] sync2_r;
  logic [N_BTN-1:0] state_r;
  logic [N_BTN-1:0] press_r;
  logic [N_BTN-1:0] release_r;
  logic [CNT_W-1:0] cnt_r   [N_BTN];
  logic [3:0]       count_r [N_BTN];
  logic [N_BTN-1:0] accept_s;

  // Two-flop synchronizer; pins are inverted so 1 means pressed.
  always_ff @(posedge ti_clk) begin
    if (reset) begin
      sync1_r <= {N_BTN{1'b0}};
      sync2_r <= {N_BTN{1'b0}};
    end else begin
      sync1_r <= ~bus.btn_n;
      sync2_r <= sync1_r;
    end
  end

  // A level change is accepted once it has been stable for the full window.
  always_comb begin
    accept_s = {N_BTN{1'b0}};
    for (int i = 0; i < N_BTN; i++) begin
      if ((sync2_r[i] != state_r[i]) && (cnt_r[i] == CNT_LAST)) begin
        accept_s[i] = 1'b1;
      end else begin
        accept_s[i] = 1'b0;
      end
    end
  end

  // Stability counters: any agreement with the current state restarts the window.
  always_ff @(posedge ti_clk) begin
    if (reset) begin
      for (int i = 0; i < N_BTN; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if ((sync2_r[i] == state_r[i]) || accept_s[i]) begin
          cnt_r[i] <= {CNT_W{1'b0}};
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced state and edge pulses, all landing on the acceptance edge.
  always_ff @(posedge ti_clk) begin
    if (reset) begin
      state_r   <= {N_BTN{1'b0}};
      press_r   <= {N_BTN{1'b0}};
      release_r <= {N_BTN{1'b0}};
    end else begin
      state_r   <= state_r ^ accept_s;
      press_r   <= accept_s & sync2_r;
      release_r <= accept_s & ~sync2_r;
    end
  end

  // Press counters wrap modulo 16; clear beats a coincident press.
  always_ff @(posedge ti_clk) begin
    if (reset || bus.clear_counts) begin
      for (int i = 0; i < N_BTN; i++) begin
        count_r[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (accept_s[i] && sync2_r[i]) begin
          count_r[i] <= count_r[i] + 4'd1;
        end else begin
          count_r[i] <= count_r[i];
        end
      end
    end
  end

  assign bus.btn_state   = state_r;
  assign bus.btn_press   = press_r;
  assign bus.btn_release = release_r;

  for (genvar g = 0; g < N_BTN; g++) begin : g_count
    assign bus.press_count[4*g +: 4] = count_r[g];
  end

endmodule

// File: tb/tb_fp_button_capture.sv
// Directed bench for fp_button_capture with DEBOUNCE_CYCLES = 4, N_BTN = 4.
module tb_fp_button_capture;

  logic ti_clk = 1'b0;
  logic reset  = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  fp_button_capture_if #(.N_BTN(4)) bus ();

  fp_button_capture #(
    .N_BTN(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .ti_clk(ti_clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 ti_clk = ~ti_clk;

  task automatic tick(input int n);
    repeat (n) @(negedge ti_clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.btn_n        = 4'b0000;
    bus.clear_counts = 1'b0;
    reset            = 1'b1;

    // Reset with every button held down.
    tick(1);
    check("rst_state", 16'(bus.btn_state), 16'h0);
    check("rst_press", 16'(bus.btn_press), 16'h0);
    check("rst_release", 16'(bus.btn_release), 16'h0);
    check("rst_count", bus.press_count, 16'h0000);
    tick(2);
    check("rst_state_late", 16'(bus.btn_state), 16'h0);
    reset = 1'b0;
    tick(5);
    check("rst_held_early", 16'(bus.btn_state), 16'h0);
    check("rst_held_nopulse", 16'(bus.btn_press), 16'h0);
    tick(1);
    check("rst_held_state", 16'(bus.btn_state), 16'hF);
    check("rst_held_press", 16'(bus.btn_press), 16'hF);
    check("rst_held_count", bus.press_count, 16'h1111);
    tick(1);
    check("rst_held_pulse_end", 16'(bus.btn_press), 16'h0);

    // Release everything; releases do not count.
    bus.btn_n = 4'b1111;
    tick(5);
    check("rel_all_early", 16'(bus.btn_state), 16'hF);
    tick(1);
    check("rel_all_state", 16'(bus.btn_state), 16'h0);
    check("rel_all_release", 16'(bus.btn_release), 16'hF);
    check("rel_all_count", bus.press_count, 16'h1111);

    // Clean press and release of button 0.
    bus.btn_n = 4'b1110;
    tick(5);
    check("b0_press_early", 16'(bus.btn_state), 16'h0);
    tick(1);
    check("b0_press_state", 16'(bus.btn_state), 16'h1);
    check("b0_press_pulse", 16'(bus.btn_press), 16'h1);
    check("b0_press_count", bus.press_count, 16'h1112);
    tick(1);
    check("b0_press_width", 16'(bus.btn_press), 16'h0);
    bus.btn_n = 4'b1111;
    tick(5);
    check("b0_rel_early", 16'(bus.btn_state), 16'h1);
    tick(1);
    check("b0_rel_state", 16'(bus.btn_state), 16'h0);
    check("b0_rel_pulse", 16'(bus.btn_release), 16'h1);
    check("b0_rel_nopress", 16'(bus.btn_press), 16'h0);
    check("b0_rel_count", bus.press_count, 16'h1112);
    tick(1);
    check("b0_rel_width", 16'(bus.btn_release), 16'h0);

    // Bounce on button 1: 2-cycle toggles never reach the window.
    for (int k = 0; k < 10; k++) begin
      bus.btn_n = (k % 2 == 0) ? 4'b1101 : 4'b1111;
      tick(2);
      check("b1_bounce_state", 16'(bus.btn_state), 16'h0);
      check("b1_bounce_press", 16'(bus.btn_press), 16'h0);
    end
    bus.btn_n = 4'b1101;
    tick(5);
    check("b1_hold_early", 16'(bus.btn_state), 16'h0);
    tick(1);
    check("b1_hold_state", 16'(bus.btn_state), 16'h2);
    check("b1_hold_press", 16'(bus.btn_press), 16'h2);
    check("b1_hold_count", bus.press_count, 16'h1122);
    bus.btn_n = 4'b1111;
    tick(6);
    check("b1_rel_pulse", 16'(bus.btn_release), 16'h2);

    // Clear all counters, one-cycle latency.
    bus.clear_counts = 1'b1;
    tick(1);
    check("clear_count", bus.press_count, 16'h0000);
    bus.clear_counts = 1'b0;
    tick(1);

    // Button 2 wrap: 1..15, 0, 1.
    for (int k = 0; k < 17; k++) begin
      bus.btn_n = 4'b1011;
      tick(6);
      check("b2_wrap_press", 16'(bus.btn_press), 16'h4);
      check("b2_wrap_count", 16'(bus.press_count[11:8]), 16'((k + 1) % 16));
      bus.btn_n = 4'b1111;
      tick(6);
    end

    // Bring button 3 to count 5.
    for (int k = 0; k < 5; k++) begin
      bus.btn_n = 4'b0111;
      tick(6);
      bus.btn_n = 4'b1111;
      tick(6);
    end
    check("b3_pre_count", bus.press_count, 16'h5100);

    // Clear on the exact acceptance edge of a button-3 press.
    bus.btn_n = 4'b0111;
    tick(5);
    bus.clear_counts = 1'b1;
    tick(1);
    check("coll_count", bus.press_count, 16'h0000);
    check("coll_press", 16'(bus.btn_press), 16'h8);
    check("coll_state", 16'(bus.btn_state), 16'h8);
    bus.clear_counts = 1'b0;
    bus.btn_n = 4'b1111;
    tick(6);
    check("coll_rel_state", 16'(bus.btn_state), 16'h0);

    // Simultaneous: press 0 and 3 while releasing 1.
    bus.btn_n = 4'b1101;
    tick(6);
    check("sim_pre_state", 16'(bus.btn_state), 16'h2);
    check("sim_pre_count", bus.press_count, 16'h0010);
    bus.btn_n = 4'b0110;
    tick(5);
    check("sim_early", 16'(bus.btn_press), 16'h0);
    tick(1);
    check("sim_press", 16'(bus.btn_press), 16'h9);
    check("sim_release", 16'(bus.btn_release), 16'h2);
    check("sim_state", 16'(bus.btn_state), 16'h9);
    check("sim_count", bus.press_count, 16'h1011);

    // Reset mid-debounce discards progress; held button is re-accepted.
    bus.btn_n = 4'b0111;
    tick(2);
    reset = 1'b1;
    tick(1);
    check("rst2_state", 16'(bus.btn_state), 16'h0);
    check("rst2_count", bus.press_count, 16'h0000);
    reset = 1'b0;
    tick(5);
    check("rst2_early", 16'(bus.btn_state), 16'h0);
    tick(1);
    check("rst2_state_held", 16'(bus.btn_state), 16'h8);
    check("rst2_press", 16'(bus.btn_press), 16'h8);
    check("rst2_count_held", bus.press_count, 16'h1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
